// File: rtl/adder_pkg.sv
// Shared types and constants for the shared-adder arbiter and its helpers.
package adder_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_NREQ  = 4;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t EXEC = 2'd1;
    localparam state_t DONE = 2'd2;

    // A single requester would give $clog2(1)=0, so clamp the index width to at least one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/carry_select_adder.sv
// WIDTH-bit carry-select adder, bit-exact to a + b + cin with carry-out in sum[WIDTH].
module carry_select_adder #(
    parameter int WIDTH = 32,
    parameter int BLK   = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH:0]   sum
);

    localparam int NBLK = (WIDTH + BLK - 1) / BLK;

    logic             carry [NBLK+1];
    logic [WIDTH-1:0] s;

    assign carry[0] = cin;

    // Each block precomputes both carry-in cases; the incoming carry only drives a mux.
    for (genvar i = 0; i < NBLK; i++) begin : g_blk
        localparam int LO = i * BLK;
        localparam int W  = ((WIDTH - LO) < BLK) ? (WIDTH - LO) : BLK;

        logic [W:0] s0;
        logic [W:0] s1;

        assign s0 = {1'b0, a[LO +: W]} + {1'b0, b[LO +: W]};
        assign s1 = {1'b0, a[LO +: W]} + {1'b0, b[LO +: W]} + {{W{1'b0}}, 1'b1};

        assign s[LO +: W]   = carry[i] ? s1[W-1:0] : s0[W-1:0];
        assign carry[i + 1] = carry[i] ? s1[W]     : s0[W];
    end

    assign sum = {carry[NBLK], s};

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or after rr_ptr, wrapping.
module rr_pick
    import adder_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    localparam int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    output logic            any,
    output logic [NREQ-1:0] onehot,
    output logic [IDW-1:0]  idx
);

    int p;

    always_comb begin
        any    = 1'b0;
        onehot = '0;
        idx    = '0;
        p      = 0;
        for (int k = 0; k < NREQ; k++) begin
            p = (int'(rr_ptr) + k) % NREQ;
            if (!any && req[p]) begin
                any       = 1'b1;
                onehot[p] = 1'b1;
                idx       = p[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// One adder core shared among NREQ clients: round-robin grant, registered operands,
// registered result held under valid/ready backpressure.
module adder_share_arbiter
    import adder_pkg::*;
#(
    parameter  int NREQ  = DEF_NREQ,
    parameter  int WIDTH = DEF_WIDTH,
    localparam int IDW   = id_width(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] A,
    input  logic [NREQ*WIDTH-1:0] B,
    input  logic [NREQ-1:0]       Cin,
    output logic [NREQ-1:0]       gnt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IDW-1:0]        out_id,
    output logic [WIDTH:0]        Sum,
    output logic                  Cout,
    output logic                  busy,
    output state_t                dbg_state
);

    // Handshake: a result transfers on any rising edge where out_valid && out_ready;
    // out_valid never drops and Sum/out_id never change until that transfer happens.

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   rr_next;
    logic [IDW-1:0]   win_idx;
    logic [NREQ-1:0]  win_onehot;
    logic             win_any;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_cin;
    logic [IDW-1:0]   op_id;

    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             sel_cin;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sum_q;

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .any    (win_any),
        .onehot (win_onehot),
        .idx    (win_idx)
    );

    carry_select_adder #(
        .WIDTH (WIDTH)
    ) u_add (
        .a   (op_a),
        .b   (op_b),
        .cin (op_cin),
        .sum (add_sum)
    );

    assign sel_a   = A[int'(win_idx) * WIDTH +: WIDTH];
    assign sel_b   = B[int'(win_idx) * WIDTH +: WIDTH];
    assign sel_cin = Cin[win_idx];
    assign rr_next = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            gnt       <= '0;
            out_valid <= 1'b0;
            out_id    <= '0;
            sum_q     <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_cin    <= 1'b0;
            op_id     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_any) begin
                        op_a   <= sel_a;
                        op_b   <= sel_b;
                        op_cin <= sel_cin;
                        op_id  <= win_idx;
                        gnt    <= win_onehot;
                        rr_ptr <= rr_next;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    sum_q     <= add_sum;
                    out_id    <= op_id;
                    out_valid <= 1'b1;
                    gnt       <= '0;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    gnt       <= '0;
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign Sum       = sum_q;
    assign Cout      = sum_q[WIDTH];
    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: per-cycle transaction model plus directed literal checks.
module tb_adder_share_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] A = '0;
    logic [NREQ*WIDTH-1:0] B = '0;
    logic [NREQ-1:0]       Cin = '0;
    logic                  out_ready = 1'b0;
    logic [NREQ-1:0]       gnt;
    logic                  out_valid;
    logic [1:0]            out_id;
    logic [WIDTH:0]        Sum;
    logic                  Cout;
    logic                  busy;
    logic [1:0]            dbg_state;

    adder_share_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .Sum       (Sum),
        .Cout      (Cout),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int grant_log[$];
    logic [34:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one operation = grant edge, result edge, then hold until accepted.
    int              m_ptr = 0;
    int              m_phase = 0;
    logic [NREQ-1:0] e_gnt = '0;
    logic            e_valid = 1'b0;
    logic [1:0]      e_id = '0;
    logic [WIDTH:0]  e_sum = '0;

    initial begin
        logic [NREQ-1:0]       req_s;
        logic [NREQ*WIDTH-1:0] a_s;
        logic [NREQ*WIDTH-1:0] b_s;
        logic [NREQ-1:0]       cin_s;
        logic                  rdy_s;
        logic                  rst_s;
        longint                total;
        int                    w;
        forever begin
            @(posedge clk);
            req_s = req; a_s = A; b_s = B; cin_s = Cin; rdy_s = out_ready; rst_s = rst;
            if (rst_s) begin
                m_ptr = 0; m_phase = 0; e_gnt = '0; e_valid = 1'b0; e_id = '0; e_sum = '0;
                exp_q.delete();
            end else if (m_phase == 0) begin
                e_gnt = '0;
                if (req_s != '0) begin
                    w = -1;
                    for (int k = 0; k < NREQ; k++)
                        if (w < 0 && req_s[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
                    total = longint'(a_s[w*WIDTH +: WIDTH]) + longint'(b_s[w*WIDTH +: WIDTH])
                            + longint'(cin_s[w]);
                    exp_q.push_back({w[1:0], total[WIDTH:0]});
                    e_gnt[w] = 1'b1;
                    m_ptr = (w + 1) % NREQ;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                e_gnt = '0;
                e_valid = 1'b1;
                {e_id, e_sum} = exp_q[0];
                m_phase = 2;
            end else if (rdy_s) begin
                e_valid = 1'b0;
                void'(exp_q.pop_front());
                m_phase = 0;
            end
            #1;
            check("cyc_gnt", gnt, e_gnt);
            check("cyc_valid", out_valid, e_valid);
            check("cyc_id", out_id, e_id);
            check("cyc_sum", Sum, e_sum);
            check("cyc_cout", Cout, e_sum[WIDTH]);
            check("cyc_busy", busy, m_phase != 0);
            check("cyc_state", dbg_state, m_phase[1:0]);
            for (int i = 0; i < NREQ; i++)
                if (gnt[i]) grant_log.push_back(i);
        end
    end

    // Every requester drops its req on the cycle it sees its own grant.
    task automatic cycle();
        @(negedge clk);
        req = req & ~gnt;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            cycle();
            n++;
        end
        if (!out_valid) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_grants(input int count);
        int n;
        n = 0;
        while (grant_log.size() < count && n < 80) begin
            cycle();
            n++;
        end
        n = 0;
        while ((busy || req != '0) && n < 20) begin
            cycle();
            n++;
        end
    endtask

    function automatic int log_at(input int i);
        return (i < grant_log.size()) ? grant_log[i] : -1;
    endfunction

    initial begin
        // reset
        repeat (3) cycle();
        check("rst_gnt", gnt, 0);
        check("rst_valid", out_valid, 0);
        check("rst_sum", Sum, 0);
        check("rst_busy", busy, 0);
        check("rst_id", out_id, 0);
        rst = 1'b0;

        // basic
        A[0 +: 32] = 32'h0000_0005; B[0 +: 32] = 32'h0000_0003; Cin[0] = 1'b0;
        out_ready = 1'b1;
        req = 4'b0001;
        cycle();
        check("basic_gnt", gnt, 4'b0001);
        cycle();
        check("basic_valid", out_valid, 1);
        check("basic_id", out_id, 0);
        check("basic_sum", Sum, 33'h0_0000_0008);
        check("basic_cout", Cout, 0);
        cycle();

        // overflow
        A[32 +: 32] = 32'hFFFF_FFFF; B[32 +: 32] = 32'h0000_0001; Cin[1] = 1'b1;
        req = 4'b0010;
        wait_valid("ovf");
        check("ovf_sum", Sum, 33'h1_0000_0001);
        check("ovf_cout", Cout, 1);
        check("ovf_id", out_id, 1);
        cycle();

        // round-robin from a fresh pointer
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        grant_log.delete();
        req = 4'b1111;
        wait_grants(4);
        check("rr_count", grant_log.size(), 4);
        for (int i = 0; i < 4; i++) check("rr_order", log_at(i), i);
        req = 4'b1001;
        wait_grants(6);
        check("rr_wrap_a", log_at(4), 0);
        check("rr_wrap_b", log_at(5), 3);

        // backpressure, then operand isolation on requester 2
        out_ready = 1'b0;
        A[64 +: 32] = 32'h10; B[64 +: 32] = 32'h5; Cin[2] = 1'b0;
        req = 4'b0001;
        wait_valid("bp");
        req = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("bp_valid", out_valid, 1);
            check("bp_sum", Sum, 33'h0_0000_0008);
            check("bp_id", out_id, 0);
            check("bp_nognt", gnt, 0);
        end
        out_ready = 1'b1;
        cycle();
        check("bp_release", out_valid, 0);
        cycle();
        check("bp_gnt", gnt, 4'b0100);
        A[64 +: 32] = 32'h20;
        wait_valid("iso");
        check("iso_sum", Sum, 33'h0_0000_0015);
        check("iso_id", out_id, 2);
        cycle();

        // reset in EXEC
        req = 4'b1000;
        cycle();
        check("mid_gnt", gnt, 4'b1000);
        rst = 1'b1;
        #1;
        check("mid_gnt0", gnt, 0);
        check("mid_valid0", out_valid, 0);
        check("mid_sum0", Sum, 0);
        check("mid_busy0", busy, 0);
        cycle();
        rst = 1'b0;
        req = 4'b0010;
        cycle();
        check("post_gnt", gnt, 4'b0010);
        cycle();
        check("post_valid", out_valid, 1);
        check("post_id", out_id, 1);
        check("post_sum", Sum, 33'h1_0000_0001);
        repeat (3) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
